mmio_pwm_responder: RTL and testbench

- Memory-mapped peripheral that answers CPU load/store accesses on the datapath's data-memory bus.
- Stores 8-bit PWM duty values for the LED, red, green and blue channels, and generates the active-high PWM outputs. Top-level inverts these for the pads.
- Also provides read-only free-running millisecond and microsecond counters for firmware timing.

---
 rtl/mmio_pwm_responder_if.sv | 16 +
 rtl/mmio_pwm_responder.sv | 145 ++++++++++++++
 tb/tb_mmio_pwm_responder.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_pwm_responder_if.sv
// Data-memory bus between the datapath (master) and the PWM/timebase peripheral (slave).
// Handshake: we/re are single-cycle strobes qualified by sel; a read accepted on an edge
// produces rvalid=1 for exactly the next cycle, and rdata holds its value until the next accepted read.
interface mmio_pwm_responder_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        we;
  logic        re;
  logic        sel;
  logic [31:0] rdata;
  logic        rvalid;

  modport master (output addr, wdata, wmask, we, re, input sel, rdata, rvalid);
  modport slave  (input addr, wdata, wmask, we, re, output sel, rdata, rvalid);
endinterface

// File: rtl/mmio_pwm_responder.sv
// Memory-mapped 4-channel 8-bit PWM with DUTY/CTRL registers and free-running
// millisecond/microsecond counters.
module mmio_pwm_responder #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_FFE0,
  parameter int          CLK_HZ    = 12000000
) (
  input  logic               clk,
  input  logic               reset,
  mmio_pwm_responder_if.slave bus,
  output logic               led,
  output logic               red,
  output logic               green,
  output logic               blue
);

  localparam int US_DIV = CLK_HZ / 1000000;
  localparam int US_W   = (US_DIV > 1) ? $clog2(US_DIV) : 1;
  localparam logic [US_W-1:0] US_LAST = US_W'(US_DIV - 1);

  logic [31:0]     duty_q, duty_n, shadow_q;
  logic            en_q, en_n;
  logic [7:0]      pre_q, pre_n;
  logic [31:0]     ctrl_word, ctrl_word_n;
  logic [7:0]      pcnt_q, phase_q;
  logic [3:0]      pwm_q;
  logic [US_W-1:0] us_div_q;
  logic [9:0]      ms_div_q;
  logic [31:0]     micros_q, millis_q;
  logic [31:0]     rd_mux;
  logic [1:0]      off;
  logic            wr_acc, rd_acc, duty_wr, ctrl_wr, pwm_tick, us_tick;

  assign bus.sel  = (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign off      = bus.addr[3:2];
  assign wr_acc   = bus.we & bus.sel;
  assign rd_acc   = bus.re & bus.sel;
  assign duty_wr  = wr_acc && (off == 2'd0);
  assign ctrl_wr  = wr_acc && (off == 2'd1);
  assign ctrl_word = {16'h0, pre_q, 7'h0, en_q};

  always_comb begin
    duty_n      = duty_q;
    ctrl_word_n = ctrl_word;
    for (int i = 0; i < 4; i++) begin
      if (bus.wmask[i]) begin
        duty_n[8*i +: 8]      = bus.wdata[8*i +: 8];
        ctrl_word_n[8*i +: 8] = bus.wdata[8*i +: 8];
      end
    end
  end

  assign en_n  = ctrl_wr ? ctrl_word_n[0]    : en_q;
  assign pre_n = ctrl_wr ? ctrl_word_n[15:8] : pre_q;

  always_comb begin
    rd_mux = 32'h0;
    case (off)
      2'd0:    rd_mux = duty_q;
      2'd1:    rd_mux = ctrl_word;
      2'd2:    rd_mux = millis_q;
      default: rd_mux = micros_q;
    endcase
  end

  // >= rather than == so lowering prescale below the current count still wraps promptly.
  assign pwm_tick = (pcnt_q >= pre_q);
  assign us_tick  = (us_div_q == US_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      duty_q <= 32'h0;
      en_q   <= 1'b0;
      pre_q  <= 8'h0;
    end else begin
      if (duty_wr) duty_q <= duty_n;
      en_q  <= en_n;
      pre_q <= pre_n;
    end
  end

  // Disabling (or staying disabled) parks the counters at 0; enabling starts a fresh period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_q <= 32'h0;
      phase_q  <= 8'h0;
      pcnt_q   <= 8'h0;
      pwm_q    <= 4'h0;
    end else if (!en_n) begin
      phase_q <= 8'h0;
      pcnt_q  <= 8'h0;
      pwm_q   <= 4'h0;
    end else if (!en_q) begin
      shadow_q <= duty_q;
      phase_q  <= 8'h0;
      pcnt_q   <= 8'h0;
      pwm_q    <= 4'h0;
    end else begin
      pwm_q <= {phase_q < shadow_q[31:24], phase_q < shadow_q[23:16],
                phase_q < shadow_q[15:8],  phase_q < shadow_q[7:0]};
      if (pwm_tick) begin
        pcnt_q  <= 8'h0;
        phase_q <= phase_q + 8'd1;
        if (phase_q == 8'hFF) shadow_q <= duty_q;
      end else begin
        pcnt_q <= pcnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      us_div_q <= '0;
      ms_div_q <= 10'd0;
      micros_q <= 32'h0;
      millis_q <= 32'h0;
    end else begin
      us_div_q <= us_tick ? '0 : us_div_q + 1'b1;
      if (us_tick) begin
        micros_q <= micros_q + 32'd1;
        if (ms_div_q == 10'd999) begin
          ms_div_q <= 10'd0;
          millis_q <= millis_q + 32'd1;
        end else begin
          ms_div_q <= ms_div_q + 10'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.rdata  <= 32'h0;
      bus.rvalid <= 1'b0;
    end else begin
      bus.rvalid <= rd_acc;
      if (rd_acc) bus.rdata <= rd_mux;
    end
  end

  assign {led, red, green, blue} = pwm_q;

  logic unused_ok;
  assign unused_ok = &{1'b0, bus.addr[1:0], ctrl_word_n[31:16], ctrl_word_n[7:1]};

endmodule

// File: tb/tb_mmio_pwm_responder.sv
// Randomized and directed bench for mmio_pwm_responder against an integer-level model.
module tb_mmio_pwm_responder;
  localparam logic [31:0] BASE   = 32'hFFFF_FFE0;
  localparam int          CLK_HZ = 12000000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic led, red, green, blue;
  mmio_pwm_responder_if bus ();

  mmio_pwm_responder #(.BASE_ADDR(BASE), .CLK_HZ(CLK_HZ)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .led(led), .red(red), .green(green), .blue(blue)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] exp_q[$];
  logic [31:0] m_duty, m_shadow, m_rdata, m_ctrl_new, m_duty_new;
  logic        m_en, m_en_new, m_rvalid, m_hit;
  logic [3:0]  m_out;
  logic [1:0]  m_off;
  int          m_pre, m_pcnt, m_phase;
  longint      m_edges;

  function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [3:0] pwm_of(input int ph, input logic [31:0] sh);
    logic [3:0] r;
    for (int c = 0; c < 4; c++) r[c] = (ph < int'(sh[8*c +: 8]));
    return r;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_duty = 0; m_shadow = 0; m_rdata = 0; m_en = 0; m_rvalid = 0; m_out = 0;
      m_pre = 0; m_pcnt = 0; m_phase = 0; m_edges = 0;
      exp_q.delete();
    end else begin
      m_hit = (bus.addr[31:4] == BASE[31:4]);
      m_off = bus.addr[3:2];
      m_rvalid = bus.re && m_hit;
      if (m_rvalid) begin
        case (m_off)
          2'd0: m_rdata = m_duty;
          2'd1: m_rdata = {16'h0, 8'(m_pre), 7'h0, m_en};
          2'd2: m_rdata = 32'(m_edges / (CLK_HZ / 1000));
          default: m_rdata = 32'(m_edges / (CLK_HZ / 1000000));
        endcase
        exp_q.push_back(m_rdata);
      end
      m_duty_new = m_duty;
      m_ctrl_new = {16'h0, 8'(m_pre), 7'h0, m_en};
      if (bus.we && m_hit && m_off == 2'd0) m_duty_new = lanes(m_duty, bus.wdata, bus.wmask);
      if (bus.we && m_hit && m_off == 2'd1) m_ctrl_new = lanes(m_ctrl_new, bus.wdata, bus.wmask);
      m_en_new = m_ctrl_new[0];
      if (!m_en_new) begin
        m_phase = 0; m_pcnt = 0; m_out = 0;
      end else if (!m_en) begin
        m_phase = 0; m_pcnt = 0; m_out = 0; m_shadow = m_duty;
      end else begin
        m_out = pwm_of(m_phase, m_shadow);
        if (m_pcnt >= m_pre) begin
          m_pcnt = 0;
          m_phase = (m_phase + 1) % 256;
          if (m_phase == 0) m_shadow = m_duty;
        end else begin
          m_pcnt++;
        end
      end
      m_duty = m_duty_new;
      m_en = m_en_new;
      m_pre = int'(m_ctrl_new[15:8]);
      m_edges++;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [31:0] got;
  always @(posedge clk) begin
    #1;
    chk("sel", 32'(bus.sel), 32'(bus.addr[31:4] == BASE[31:4]));
    chk("rvalid", 32'(bus.rvalid), 32'(m_rvalid));
    if (bus.rvalid) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL rdata_unexpected: got %h expected none", bus.rdata);
      end else begin
        got = exp_q.pop_front();
        chk("rdata", bus.rdata, got);
      end
    end else begin
      chk("rdata_hold", bus.rdata, m_rdata);
    end
    chk("pwm_out", 32'({led, red, green, blue}), 32'(m_out));
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic w, input logic r, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] m);
    @(negedge clk);
    bus.we = w; bus.re = r; bus.addr = a; bus.wdata = d; bus.wmask = m;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    drive(1'b1, 1'b0, a, d, m);
    idle();
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    drive(1'b0, 1'b1, a, 32'h0, 4'h0);
    idle();
    chk({name, "_rvalid"}, 32'(bus.rvalid), 32'h1);
    chk(name, bus.rdata, exp);
  endtask

  task automatic wait_phase(input int p);
    int i;
    for (i = 0; i < 5000; i++) begin
      @(posedge clk); #1;
      if (m_phase == p) break;
    end
    if (i == 5000) begin
      n_checks++; n_errors++;
      $display("FAIL wait_phase: got timeout expected phase %0d", p);
    end
  endtask

  task automatic count_period(input string name, input int e_led, input int e_red,
                              input int e_green, input int e_blue);
    int c[4];
    c = '{0, 0, 0, 0};
    for (int i = 0; i < 256; i++) begin
      @(posedge clk); #1;
      c[0] += int'(led); c[1] += int'(red); c[2] += int'(green); c[3] += int'(blue);
    end
    chk({name, "_led"},   32'(c[0]), 32'(e_led));
    chk({name, "_red"},   32'(c[1]), 32'(e_red));
    chk({name, "_green"}, 32'(c[2]), 32'(e_green));
    chk({name, "_blue"},  32'(c[3]), 32'(e_blue));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] a, d;
    int r, k;
    bus.we = 0; bus.re = 0; bus.addr = 0; bus.wdata = 0; bus.wmask = 0;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    rd("reset_duty", BASE + 32'h0, 32'h0);
    rd("reset_ctrl", BASE + 32'h4, 32'h0);
    rd("reset_millis", BASE + 32'h8, 32'h0);
    chk("reset_outs", 32'({led, red, green, blue}), 32'h0);

    wr(BASE + 32'h0, 32'h80FF_0040, 4'hF);
    wr(BASE + 32'h4, 32'h0000_0001, 4'hF);
    count_period("period1", 128, 255, 0, 64);
    count_period("period2", 128, 255, 0, 64);

    wr(BASE + 32'h0, 32'h1122_3344, 4'b0100);
    rd("masked_duty", BASE + 32'h1, 32'h8022_0040);

    wait_phase(100);
    wr(BASE + 32'h0, 32'h0000_00C0, 4'b0001);
    wait_phase(0);
    count_period("newduty", 128, 34, 0, 192);

    for (k = 0; k < 600 && !led; k++) begin @(posedge clk); #1; end
    chk("led_high_before_clear", 32'(led), 32'h1);
    wr(BASE + 32'h4, 32'h0, 4'hF);
    chk("clear_outs", 32'({led, red, green, blue}), 32'h0);
    wr(BASE + 32'h4, 32'h1, 4'hF);
    chk("reenable_first", 32'({led, red, green, blue}), 32'h0);
    @(negedge clk);
    chk("reenable_phase0", 32'({led, red, green, blue}), 32'b1101);

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 9);
      a = BASE + 32'($urandom_range(0, 4)) * 4 + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = $urandom;
      d = $urandom;
      if (a[3:2] == 2'd1) begin
        d[0] = ($urandom_range(0, 7) != 0);
        d[15:8] = 8'($urandom_range(0, 3));
      end
      drive(r < 4, (r >= 3) && (r < 7), a, d, 4'($urandom_range(0, 15)));
    end
    idle();

    drive(1'b0, 1'b1, BASE + 32'h0, 32'h0, 4'h0);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("midread_rvalid", 32'(bus.rvalid), 32'h0);
    chk("midread_outs", 32'({led, red, green, blue}), 32'h0);
    @(negedge clk);
    bus.we = 0; bus.re = 0; bus.addr = 0;
    reset = 1'b1;
    repeat (12000) @(posedge clk);
    rd("micros_12000", BASE + 32'hC, 32'd1000);
    rd("millis_12000", BASE + 32'h8, 32'd1);
    wr(BASE + 32'h8, 32'hFFFF_FFFF, 4'hF);
    rd("millis_ro", BASE + 32'h8, 32'd1);

    drive(1'b1, 1'b1, BASE + 32'h10, 32'hFFFF_FFFF, 4'hF);
    #1;
    chk("outside_sel", 32'(bus.sel), 32'h0);
    idle();
    chk("outside_rvalid", 32'(bus.rvalid), 32'h0);
    rd("outside_nochange", BASE + 32'h0, 32'h0);

    repeat (3) idle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
